regfile_bypass_sb: RTL and testbench

Parametrised general-purpose register file with HI/LO pair, N read ports, M prioritised bypass sources and a per-register pending-write scoreboard. Sits in the ID stage and feeds operand values, HI/LO values and hazard indications to decode/issue. The pipeline stages supply bypass buses and the WB stage supplies the architectural write port.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_bypass_sb_fwd_sel.sv | 45 ++++
 rtl/regfile_bypass_sb.sv | 167 ++++++++++++++++
 tb/tb_regfile_bypass_sb.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and packed-bus slice helpers for the register file
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREG   = 32;
  localparam int DEF_ADDR_W = $clog2(DEF_NREG);

  // Bit offset of element idx inside a packed bus of width-wide elements.
  function automatic int slice_off(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_bypass_sb_fwd_sel.sv
// rtl/regfile_bypass_sb_fwd_sel.sv - priority selector: r0, youngest bypass, write port, array
module fwd_sel
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NFWD   = 3
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic [NFWD-1:0]        fwd_we,
  input  logic [NFWD-1:0]        fwd_ready,
  input  logic [NFWD*ADDR_W-1:0] fwd_addr,
  input  logic [NFWD*DATA_W-1:0] fwd_data,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W-1:0]      arr_data,
  output logic [DATA_W-1:0]      sel_data,
  output logic                   sel_stall
);

  logic hit;

  always_comb begin
    sel_data  = arr_data;
    sel_stall = 1'b0;
    hit       = 1'b0;
    if (addr == '0) begin
      sel_data = '0;
      hit      = 1'b1;
    end
    // Lowest index is the youngest source, so the first match wins.
    for (int i = 0; i < NFWD; i++) begin
      if (!hit && fwd_we[i] && (fwd_addr[slice_off(i, ADDR_W) +: ADDR_W] == addr)) begin
        sel_data  = fwd_data[slice_off(i, DATA_W) +: DATA_W];
        sel_stall = !fwd_ready[i];
        hit       = 1'b1;
      end
    end
    if (!hit && wr_en && (wr_addr == addr)) begin
      sel_data = wr_data;
    end
  end

endmodule

// File: rtl/regfile_bypass_sb.sv
// rtl/regfile_bypass_sb.sv - GPR file with HI/LO, prioritised bypass and pending-write scoreboard
module regfile_bypass_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  parameter int NRD    = 2,
  parameter int NFWD   = 3,
  parameter int CNT_W  = 2,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD*ADDR_W-1:0]  rd_addr,
  output logic [NRD*DATA_W-1:0]  rd_data,
  output logic [NRD-1:0]         rd_stall,
  input  logic [NFWD-1:0]        fwd_we,
  input  logic [NFWD-1:0]        fwd_ready,
  input  logic [NFWD*ADDR_W-1:0] fwd_addr,
  input  logic [NFWD*DATA_W-1:0] fwd_data,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   hi_we,
  input  logic                   lo_we,
  input  logic [DATA_W-1:0]      hi_wdata,
  input  logic [DATA_W-1:0]      lo_wdata,
  input  logic [NFWD-1:0]        fwd_hi_we,
  input  logic [NFWD-1:0]        fwd_lo_we,
  input  logic [NFWD*DATA_W-1:0] fwd_hi,
  input  logic [NFWD*DATA_W-1:0] fwd_lo,
  output logic [DATA_W-1:0]      hi_rdata,
  output logic [DATA_W-1:0]      lo_rdata,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic                   iss_ok,
  input  logic                   sb_flush,
  output logic [NREG-1:0]        sb_busy,
  output logic                   sb_err
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  // HI/LO reuse the GPR selector with a fixed non-zero address that every source matches.
  localparam logic [ADDR_W-1:0] HILO_ADDR = ADDR_W'(1);

  logic [DATA_W-1:0] mem [NREG];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [CNT_W-1:0]  cnt [NREG];
  logic              ret_zero;
  logic              hi_stall_unused;
  logic              lo_stall_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (wr_en && (wr_addr != '0)) mem[wr_addr] <= wr_data;
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end
  end

  // A same-cycle retire frees a slot, so a saturated register can still accept an issue.
  assign iss_ok = !((cnt[iss_addr] == CNT_MAX) && !(wr_en && (wr_addr == iss_addr)));

  assign cnt[0]     = '0;
  assign sb_busy[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_sb
    logic [CNT_W-1:0] cnt_q;
    logic             inc;
    logic             dec;

    assign inc = iss_en && iss_ok && (iss_addr == ADDR_W'(r));
    assign dec = wr_en && (wr_addr == ADDR_W'(r));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (sb_flush) begin
        cnt_q <= '0;
      end else if (inc && !dec) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (dec && !inc && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end

    assign cnt[r]     = cnt_q;
    assign sb_busy[r] = (cnt_q != '0);
  end

  assign ret_zero = wr_en && (wr_addr != '0) && (cnt[wr_addr] == '0) && !sb_flush &&
                    !(iss_en && iss_ok && (iss_addr == wr_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else if (ret_zero) begin
      sb_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] port_addr;

    assign port_addr = rd_addr[slice_off(i, ADDR_W) +: ADDR_W];

    fwd_sel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NFWD   (NFWD)
    ) u_sel (
      .addr      (port_addr),
      .fwd_we    (fwd_we),
      .fwd_ready (fwd_ready),
      .fwd_addr  (fwd_addr),
      .fwd_data  (fwd_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .arr_data  (mem[port_addr]),
      .sel_data  (rd_data[slice_off(i, DATA_W) +: DATA_W]),
      .sel_stall (rd_stall[i])
    );
  end

  fwd_sel #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NFWD   (NFWD)
  ) u_hi_sel (
    .addr      (HILO_ADDR),
    .fwd_we    (fwd_hi_we),
    .fwd_ready ({NFWD{1'b1}}),
    .fwd_addr  ({NFWD{HILO_ADDR}}),
    .fwd_data  (fwd_hi),
    .wr_en     (hi_we),
    .wr_addr   (HILO_ADDR),
    .wr_data   (hi_wdata),
    .arr_data  (hi_q),
    .sel_data  (hi_rdata),
    .sel_stall (hi_stall_unused)
  );

  fwd_sel #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NFWD   (NFWD)
  ) u_lo_sel (
    .addr      (HILO_ADDR),
    .fwd_we    (fwd_lo_we),
    .fwd_ready ({NFWD{1'b1}}),
    .fwd_addr  ({NFWD{HILO_ADDR}}),
    .fwd_data  (fwd_lo),
    .wr_en     (lo_we),
    .wr_addr   (HILO_ADDR),
    .wr_data   (lo_wdata),
    .arr_data  (lo_q),
    .sel_data  (lo_rdata),
    .sel_stall (lo_stall_unused)
  );

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb/tb_regfile_bypass_sb.sv - directed and random checks of regfile_bypass_sb against a behavioural model
module tb_regfile_bypass_sb;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NF  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] ra     [NRD];
  logic [NF-1:0] f_we, f_rdy, f_hwe, f_lwe;
  logic [AW-1:0] f_addr [NF];
  logic [DW-1:0] f_data [NF];
  logic [DW-1:0] f_hi   [NF];
  logic [DW-1:0] f_lo   [NF];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          hi_we, lo_we;
  logic [DW-1:0] hi_wdata, lo_wdata;
  logic          iss_en;
  logic [AW-1:0] iss_addr;
  logic          sb_flush;

  logic [NRD*AW-1:0] rd_addr_bus;
  logic [NF*AW-1:0]  fwd_addr_bus;
  logic [NF*DW-1:0]  fwd_data_bus, fwd_hi_bus, fwd_lo_bus;

  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_stall;
  logic [DW-1:0]     hi_rdata, lo_rdata;
  logic              iss_ok;
  logic [NR-1:0]     sb_busy;
  logic              sb_err;

  always_comb begin
    rd_addr_bus  = '0;
    fwd_addr_bus = '0;
    fwd_data_bus = '0;
    fwd_hi_bus   = '0;
    fwd_lo_bus   = '0;
    for (int p = 0; p < NRD; p++) rd_addr_bus[p*AW +: AW] = ra[p];
    for (int s = 0; s < NF; s++) begin
      fwd_addr_bus[s*AW +: AW] = f_addr[s];
      fwd_data_bus[s*DW +: DW] = f_data[s];
      fwd_hi_bus[s*DW +: DW]   = f_hi[s];
      fwd_lo_bus[s*DW +: DW]   = f_lo[s];
    end
  end

  regfile_bypass_sb dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr_bus),
    .rd_data   (rd_data),
    .rd_stall  (rd_stall),
    .fwd_we    (f_we),
    .fwd_ready (f_rdy),
    .fwd_addr  (fwd_addr_bus),
    .fwd_data  (fwd_data_bus),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .hi_wdata  (hi_wdata),
    .lo_wdata  (lo_wdata),
    .fwd_hi_we (f_hwe),
    .fwd_lo_we (f_lwe),
    .fwd_hi    (fwd_hi_bus),
    .fwd_lo    (fwd_lo_bus),
    .hi_rdata  (hi_rdata),
    .lo_rdata  (lo_rdata),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_ok    (iss_ok),
    .sb_flush  (sb_flush),
    .sb_busy   (sb_busy),
    .sb_err    (sb_err)
  );

  // Architectural state of the reference model.
  logic [DW-1:0] m_mem [NR];
  logic [DW-1:0] m_hi, m_lo;
  int            m_cnt [NR];
  bit            m_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_mem[r] = '0;
      m_cnt[r] = 0;
    end
    m_hi  = '0;
    m_lo  = '0;
    m_err = 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    for (int s = 0; s < NF; s++) if (f_we[s] && f_addr[s] == a) return f_data[s];
    if (wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_stall(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    for (int s = 0; s < NF; s++) if (f_we[s] && f_addr[s] == a) return !f_rdy[s];
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_hi();
    for (int s = 0; s < NF; s++) if (f_hwe[s]) return f_hi[s];
    return hi_we ? hi_wdata : m_hi;
  endfunction

  function automatic logic [DW-1:0] exp_lo();
    for (int s = 0; s < NF; s++) if (f_lwe[s]) return f_lo[s];
    return lo_we ? lo_wdata : m_lo;
  endfunction

  function automatic bit exp_iss_ok();
    return !(m_cnt[iss_addr] == 3 && !(wr_en && wr_addr == iss_addr));
  endfunction

  function automatic logic [NR-1:0] exp_busy();
    logic [NR-1:0] b;
    b = '0;
    for (int r = 1; r < NR; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic model_update();
    bit ok, iss, ret;
    int ia, wa;
    if (rst) begin
      model_reset();
      return;
    end
    ia  = int'(iss_addr);
    wa  = int'(wr_addr);
    ok  = exp_iss_ok();
    iss = iss_en && ia != 0 && ok;
    ret = wr_en && wa != 0;
    if (ret) m_mem[wa] = wr_data;
    if (hi_we) m_hi = hi_wdata;
    if (lo_we) m_lo = lo_wdata;
    if (sb_flush) begin
      for (int r = 0; r < NR; r++) m_cnt[r] = 0;
    end else if (!(iss && ret && ia == wa)) begin
      if (iss) m_cnt[ia]++;
      if (ret) begin
        if (m_cnt[wa] == 0) m_err = 1'b1;
        else m_cnt[wa]--;
      end
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("rd_data%0d", p), rd_data[p*DW +: DW], exp_rd(ra[p]));
      chk($sformatf("rd_stall%0d", p), rd_stall[p], exp_stall(ra[p]));
    end
    chk("hi_rdata", hi_rdata, exp_hi());
    chk("lo_rdata", lo_rdata, exp_lo());
    chk("iss_ok", iss_ok, exp_iss_ok());
    chk("sb_busy", sb_busy, exp_busy());
    chk("sb_err", sb_err, m_err);
  endtask

  // Inputs change at the falling edge; outputs are checked 1 time unit later.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    for (int p = 0; p < NRD; p++) ra[p] = '0;
    f_we = '0; f_rdy = '1; f_hwe = '0; f_lwe = '0;
    for (int s = 0; s < NF; s++) begin
      f_addr[s] = '0; f_data[s] = '0; f_hi[s] = '0; f_lo[s] = '0;
    end
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    hi_we = 1'b0; lo_we = 1'b0; hi_wdata = '0; lo_wdata = '0;
    iss_en = 1'b0; iss_addr = '0; sb_flush = 1'b0;
  endtask

  task automatic issue(input int r);
    idle(); iss_en = 1'b1; iss_addr = AW'(r); step();
  endtask

  task automatic retire(input int r, input logic [DW-1:0] d);
    idle(); wr_en = 1'b1; wr_addr = AW'(r); wr_data = d; step();
  endtask

  initial begin
    model_reset();
    idle();
    rst = 1'b1;
    #1;
    chk("reset_busy", sb_busy, '0);
    chk("reset_err", sb_err, 1'b0);
    step();
    rst = 1'b0;

    // basic write / read, r0 behaviour
    issue(5);
    retire(5, 32'h1234);
    idle(); ra[0] = 5; ra[1] = 0;
    #1;
    chk("r5_read", rd_data[DW-1:0], 32'h1234);
    chk("r0_read", rd_data[2*DW-1:DW], 32'h0);
    step();
    idle(); wr_en = 1'b1; wr_addr = 0; wr_data = 32'hDEAD_BEEF; step();
    idle(); ra[0] = 0;
    #1 chk("r0_after_write", rd_data[DW-1:0], 32'h0);
    step();

    // bypass priority
    issue(7);
    retire(7, 32'hB);
    idle(); ra[0] = 7;
    f_we = 3'b101; f_addr[0] = 7; f_data[0] = 32'hA; f_addr[2] = 7; f_data[2] = 32'hC;
    #1 chk("fwd_prio0", rd_data[DW-1:0], 32'hA);
    step();
    f_we[0] = 1'b0;
    #1 chk("fwd_prio2", rd_data[DW-1:0], 32'hC);
    step();

    // stall on not-ready bypass source
    idle(); ra[1] = 3; f_we[0] = 1'b1; f_addr[0] = 3; f_data[0] = 32'h3333; f_rdy[0] = 1'b0;
    #1 chk("stall_set", rd_stall[1], 1'b1);
    step();
    f_rdy[0] = 1'b1;
    #1;
    chk("stall_clr", rd_stall[1], 1'b0);
    chk("stall_data", rd_data[2*DW-1:DW], 32'h3333);
    step();

    // scoreboard saturation, combined issue/retire, underflow
    issue(4); issue(4); issue(4);
    idle(); #1 chk("busy4_set", sb_busy[4], 1'b1);
    iss_en = 1'b1; iss_addr = 4;
    #1 chk("iss_ok_sat", iss_ok, 1'b0);
    step();
    idle(); iss_en = 1'b1; iss_addr = 4; wr_en = 1'b1; wr_addr = 4; wr_data = 32'h44;
    #1 chk("iss_ok_with_retire", iss_ok, 1'b1);
    step();
    for (int k = 0; k < 3; k++) begin
      retire(4, 32'h44);
      idle(); #1 chk("busy4_drain", sb_busy[4], (k < 2) ? 1'b1 : 1'b0);
    end
    chk("err_before_underflow", sb_err, 1'b0);
    retire(4, 32'h45);
    idle(); #1 chk("err_underflow", sb_err, 1'b1);

    // HI/LO bypass and write
    idle(); hi_we = 1'b1; hi_wdata = 32'h11; lo_we = 1'b1; lo_wdata = 32'h22; step();
    idle(); f_hwe[1] = 1'b1; f_hi[1] = 32'h55;
    #1;
    chk("hi_fwd1", hi_rdata, 32'h55);
    chk("lo_reg", lo_rdata, 32'h22);
    step();
    idle(); hi_we = 1'b1; hi_wdata = 32'h77; step();
    idle(); #1 chk("hi_written", hi_rdata, 32'h77);

    // asynchronous reset between edges
    issue(9);
    issue(10);
    retire(10, 32'hABC);
    idle(); ra[0] = 10;
    #2 rst = 1'b1;
    #1;
    chk("arst_rd", rd_data[DW-1:0], 32'h0);
    chk("arst_hi", hi_rdata, 32'h0);
    chk("arst_lo", lo_rdata, 32'h0);
    chk("arst_busy", sb_busy, '0);
    chk("arst_err", sb_err, 1'b0);
    model_reset();
    step();
    rst = 1'b0;

    // flush beats a same-cycle issue
    issue(2);
    issue(2);
    idle(); sb_flush = 1'b1; iss_en = 1'b1; iss_addr = 2; step();
    idle(); #1 chk("flush_busy", sb_busy, '0);
    step();

    // randomized traffic over a small register window to force hits
    for (int n = 0; n < 600; n++) begin
      idle();
      for (int p = 0; p < NRD; p++) ra[p] = AW'($urandom_range(0, 7));
      f_we  = NF'($urandom);
      f_rdy = NF'($urandom);
      f_hwe = NF'($urandom);
      f_lwe = NF'($urandom);
      for (int s = 0; s < NF; s++) begin
        f_addr[s] = AW'($urandom_range(0, 7));
        f_data[s] = $urandom;
        f_hi[s]   = $urandom;
        f_lo[s]   = $urandom;
      end
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = $urandom;
      hi_we    = ($urandom_range(0, 3) == 0);
      lo_we    = ($urandom_range(0, 3) == 0);
      hi_wdata = $urandom;
      lo_wdata = $urandom;
      iss_en   = ($urandom_range(0, 1) == 0);
      iss_addr = AW'($urandom_range(0, 7));
      sb_flush = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
